fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/rv_pkg.sv | 28 ++
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_pc_reg.sv | 30 +++
 rtl/fetch_sequencer.sv | 87 ++++++++
 tb/tb_fetch_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch sequencer: opcodes, FSM state encoding and
// default widths.
package rv_pkg;

  localparam int PC_W_DEF  = 9;
  localparam int INS_W_DEF = 32;

  localparam logic [6:0] OP_HALT = 7'b0000001;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_U    = 7'b0110111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_DROP   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  function automatic logic is_halt(input logic [6:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory request/response, decode handshake,
// branch redirect and halt status.
interface fetch_sequencer_if
  import rv_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int INS_W = INS_W_DEF
);

  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_valid;
  logic [INS_W-1:0] imem_rdata;
  logic             inst_valid;
  logic [INS_W-1:0] inst;
  logic [PC_W-1:0]  inst_pc;
  logic             inst_ready;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             halted;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
    input  imem_valid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, halted,
    output imem_valid, imem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect (word-aligned) takes priority over sequential advance.
module fetch_pc_reg
  import rv_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            advance,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_r;

  // PC update; the add wraps naturally at 2^PC_W
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= '0;
    end else if (redirect) begin
      pc_r <= redirect_pc & ~PC_W'(2'd3);
    end else if (advance) begin
      pc_r <= pc_r + PC_W'(3'd4);
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory request, holds the fetched
// word for decode, handles taken-branch redirects and stops on HALT.
module fetch_sequencer
  import rv_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int INS_W = INS_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  fetch_state_e     state_r;
  fetch_state_e     state_nxt_s;
  logic [INS_W-1:0] inst_r;
  logic [PC_W-1:0]  inst_pc_r;
  logic [PC_W-1:0]  pc_s;
  logic             redirect_s;
  logic             transfer_s;
  logic             capture_s;

  // A halted sequencer is deaf to redirects; a redirect kills any pending transfer
  assign redirect_s = bus.redirect && (state_r != ST_HALTED);
  assign transfer_s = (state_r == ST_HOLD) && bus.inst_ready && !bus.redirect;
  assign capture_s  = (state_r == ST_WAIT) && bus.imem_valid && !bus.redirect;

  fetch_pc_reg #(.PC_W(PC_W)) u_pc (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect_s),
    .redirect_pc (bus.redirect_pc),
    .advance     (transfer_s),
    .pc          (pc_s)
  );

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (bus.redirect) state_nxt_s = ST_DROP;
        else              state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.redirect)        state_nxt_s = bus.imem_valid ? ST_FETCH : ST_DROP;
        else if (bus.imem_valid) state_nxt_s = ST_HOLD;
        else                     state_nxt_s = ST_WAIT;
      end
      ST_HOLD: begin
        if (bus.redirect)        state_nxt_s = ST_FETCH;
        else if (bus.inst_ready) state_nxt_s = is_halt(inst_r[6:0]) ? ST_HALTED : ST_FETCH;
        else                     state_nxt_s = ST_HOLD;
      end
      ST_DROP: begin
        if (bus.imem_valid) state_nxt_s = ST_FETCH;
        else                state_nxt_s = ST_DROP;
      end
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_FETCH;
    endcase
  end

  // State and held-instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_FETCH;
      inst_r    <= '0;
      inst_pc_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        inst_r    <= bus.imem_rdata;
        inst_pc_r <= pc_s;
      end
    end
  end

  // Status strobes decode state only, forced low while reset is asserted
  assign bus.imem_req   = !reset && (state_r == ST_FETCH);
  assign bus.inst_valid = !reset && (state_r == ST_HOLD);
  assign bus.halted     = !reset && (state_r == ST_HALTED);
  assign bus.imem_addr  = pc_s;
  assign bus.inst       = inst_r;
  assign bus.inst_pc    = inst_pc_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: transaction-level reference model with
// an instruction-memory responder, randomized traffic and directed corner cases.
module tb_fetch_sequencer;
  import rv_pkg::*;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .INS_W(INS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: fetch pc, in-flight request, word waiting for decode, halt
  logic             m_outst, m_stale, m_pend, m_halt, m_rst_prev;
  logic [PC_W-1:0]  m_pc, m_out_addr, m_pend_pc;
  logic [INS_W-1:0] m_pend_data;

  // Memory responder knobs
  int              mem_cnt = 0;
  int              mem_delay = 1;
  logic            rand_data = 1'b0;
  logic            halt_en = 1'b0;
  logic [PC_W-1:0] halt_addr = '0;
  logic            spur_en = 1'b0;
  logic            force_valid = 1'b0;

  // Observations of the DUT
  int              cyc = 0;
  int              obs_xfer = 0;
  logic            obs_got = 1'b0;
  logic [PC_W-1:0] obs_addr = '0;
  int              xfer_pc_q[$];
  int              xfer_cyc_q[$];

  function automatic logic [INS_W-1:0] mem_word(input logic [PC_W-1:0] a);
    logic [INS_W-1:0] w;
    if (halt_en && a == halt_addr) return 32'h0000_0001;
    if (!rand_data) return 32'h0000_0013;
    w = $urandom;
    if (w[6:0] == OP_HALT) w[6:0] = OP_I;
    return w;
  endfunction

  task automatic cycle();
    logic req_e;
    logic xfer;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
    if (m_outst) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem_word(m_out_addr);
      end
    end else if (force_valid || (spur_en && $urandom_range(0, 7) == 0)) begin
      bus.imem_valid = 1'b1;
    end
    @(negedge clk);
    req_e = !reset && !m_halt && !m_outst && !m_pend;
    if (reset) begin
      check_val("rst_req", bus.imem_req, 1'b0);
      check_val("rst_ivalid", bus.inst_valid, 1'b0);
      check_val("rst_halted", bus.halted, 1'b0);
      if (m_rst_prev) begin
        check_val("rst_inst", bus.inst, '0);
        check_val("rst_inst_pc", bus.inst_pc, '0);
      end
    end else begin
      check_val("imem_req", bus.imem_req, req_e);
      check_val("inst_valid", bus.inst_valid, m_pend);
      check_val("halted", bus.halted, m_halt);
      if (req_e) check_val("imem_addr", bus.imem_addr, m_pc);
      if (m_pend) begin
        check_val("inst", bus.inst, m_pend_data);
        check_val("inst_pc", bus.inst_pc, m_pend_pc);
      end
    end
    if (bus.imem_req && !obs_got) begin
      obs_got  = 1'b1;
      obs_addr = bus.imem_addr;
    end
    if (bus.inst_valid && bus.inst_ready && !bus.redirect && !reset) begin
      obs_xfer++;
      xfer_pc_q.push_back(int'(bus.inst_pc));
      xfer_cyc_q.push_back(cyc);
    end
    if (reset) begin
      m_pc = '0; m_outst = 1'b0; m_stale = 1'b0; m_pend = 1'b0; m_halt = 1'b0;
    end else if (!m_halt) begin
      xfer = m_pend && bus.inst_ready && !bus.redirect;
      if (m_outst && bus.imem_valid) begin
        m_outst = 1'b0;
        if (!m_stale && !bus.redirect) begin
          m_pend = 1'b1; m_pend_data = bus.imem_rdata; m_pend_pc = m_out_addr;
        end
      end else if (req_e) begin
        m_outst = 1'b1; m_out_addr = m_pc; m_stale = bus.redirect;
        mem_cnt = (mem_delay == 0) ? int'($urandom_range(1, 3)) : mem_delay;
      end else if (m_outst && bus.redirect) begin
        m_stale = 1'b1;
      end
      if (bus.redirect) begin
        m_pc = bus.redirect_pc & ~PC_W'(2'd3);
        m_pend = 1'b0;
      end else if (xfer) begin
        if (m_pend_data[6:0] == OP_HALT) m_halt = 1'b1;
        m_pc = m_pc + PC_W'(3'd4);
        m_pend = 1'b0;
      end
    end
    m_rst_prev = reset;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; bus.redirect = 1'b0; bus.inst_ready = 1'b0;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic wait_pend(input string tag);
    for (int i = 0; i < 12 && !m_pend; i++) cycle();
    if (!m_pend) check_val(tag, 1'b0, 1'b1);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 12 && !obs_got; i++) cycle();
    check_val(tag, obs_got, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int halt_cyc;
    reset = 1'b1;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b0;
    bus.imem_valid = 1'b0; bus.imem_rdata = '0;
    m_outst = 1'b0; m_stale = 1'b0; m_pend = 1'b0; m_halt = 1'b0; m_rst_prev = 1'b0;
    m_pc = '0; m_out_addr = '0; m_pend_pc = '0; m_pend_data = '0;
    @(posedge clk); #1;

    // Streaming 0x13 with a one-cycle memory: pcs 0,4,8, one transfer every 3 cycles
    do_reset(3);
    xfer_pc_q.delete(); xfer_cyc_q.delete();
    bus.inst_ready = 1'b1;
    repeat (9) cycle();
    check_val("stream_count", xfer_pc_q.size(), 3);
    if (xfer_pc_q.size() >= 3) begin
      check_val("stream_pc0", xfer_pc_q[0], 0);
      check_val("stream_pc1", xfer_pc_q[1], 4);
      check_val("stream_pc2", xfer_pc_q[2], 8);
      check_val("stream_gap1", xfer_cyc_q[1] - xfer_cyc_q[0], 3);
      check_val("stream_gap2", xfer_cyc_q[2] - xfer_cyc_q[1], 3);
    end

    // Decode stalls 5 cycles in HOLD: no new request, then exactly one transfer
    bus.inst_ready = 1'b0;
    wait_pend("stall_wait_hold");
    obs_got = 1'b0;
    repeat (5) cycle();
    check_val("stall_no_req", obs_got, 1'b0);
    n0 = obs_xfer;
    bus.inst_ready = 1'b1;
    cycle();
    bus.inst_ready = 1'b0;
    check_val("stall_one_xfer", obs_xfer - n0, 1);

    // Redirect to 0x41 while waiting; stale response arrives 2 cycles later
    mem_delay = 3;
    for (int i = 0; i < 12 && !(m_outst && !m_stale); i++) cycle();
    bus.redirect = 1'b1; bus.redirect_pc = 9'h041;
    cycle();
    bus.redirect = 1'b0;
    obs_got = 1'b0;
    wait_req("wait_redir_req");
    check_val("wait_redir_addr", obs_addr, 9'h040);
    mem_delay = 1;

    // Redirect in HOLD with inst_ready=1: the held word is not transferred
    wait_pend("hold_redir_wait");
    n0 = obs_xfer;
    bus.redirect = 1'b1; bus.redirect_pc = 9'h0A3; bus.inst_ready = 1'b1;
    cycle();
    bus.redirect = 1'b0; bus.inst_ready = 1'b0;
    check_val("hold_redir_no_xfer", obs_xfer - n0, 0);
    obs_got = 1'b0;
    wait_req("hold_redir_req");
    check_val("hold_redir_addr", obs_addr, 9'h0A0);

    // PC wraps from 2^PC_W-4 to 0
    bus.redirect = 1'b1; bus.redirect_pc = 9'h1FE;
    cycle();
    bus.redirect = 1'b0;
    wait_pend("wrap_wait");
    check_val("wrap_inst_pc", bus.inst_pc, 9'h1FC);
    obs_got = 1'b0;
    bus.inst_ready = 1'b1;
    cycle();
    bus.inst_ready = 1'b0;
    wait_req("wrap_req");
    check_val("wrap_addr", obs_addr, 9'h000);

    // Randomized traffic: random latency, data, stalls, redirects, stray strobes
    rand_data = 1'b1; mem_delay = 0; spur_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      bus.inst_ready  = ($urandom_range(0, 1) == 1);
      bus.redirect    = ($urandom_range(0, 9) == 0);
      bus.redirect_pc = PC_W'($urandom);
      cycle();
    end
    bus.redirect = 1'b0;

    // HALT fetched at pc 8 stops the sequencer until reset
    rand_data = 1'b0; mem_delay = 1; spur_en = 1'b0; halt_en = 1'b1; halt_addr = 9'h008;
    do_reset(2);
    bus.inst_ready = 1'b1;
    halt_cyc = -1;
    for (int i = 0; i < 16; i++) begin
      if (bus.halted && halt_cyc < 0) halt_cyc = i;
      cycle();
    end
    check_val("halt_cycle", halt_cyc, 9);
    obs_got = 1'b0; spur_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.redirect = 1'b1; bus.redirect_pc = PC_W'($urandom);
      cycle();
    end
    bus.redirect = 1'b0; spur_en = 1'b0;
    check_val("halt_no_req", obs_got, 1'b0);
    check_val("halt_sticky", bus.halted, 1'b1);
    halt_en = 1'b0;
    do_reset(2);
    force_valid = 1'b1;
    obs_got = 1'b0;
    cycle();
    force_valid = 1'b0;
    check_val("post_rst_req", obs_got, 1'b1);
    check_val("post_rst_addr", obs_addr, 9'h000);
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
